instruction_fetch_unit: RTL and testbench

//  Sequences the byte-addressed, combinational-read instruction memory. Holds the PC, drives
//  the fetch address and registers each 32-bit little-endian word into a valid/ready fetch

---
 rtl/instruction_fetch_unit_pkg.sv | 27 ++
 rtl/instruction_fetch_unit_if.sv | 48 ++++
 rtl/instruction_fetch_unit_reg_slice.sv | 45 ++++
 rtl/instruction_fetch_unit.sv | 115 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Covers the fetch state, the fetch-register word and pc legality.
package instruction_fetch_unit_pkg;

  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 64;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_word_t;

  function automatic logic pc_legal(
    input logic [ADDR_W-1:0] pc,
    input logic [ADDR_W-1:0] last_pc
  );
    return (pc[1:0] == 2'b00) && (pc <= last_pc);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory,
// execute (redirect) and decode (valid/ready).
interface instruction_fetch_unit_if #(
  parameter int CNT_W = 32
);
  import instruction_fetch_unit_pkg::*;

  logic [ADDR_W-1:0]  imem_address;
  logic [INSTR_W-1:0] imem_data;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instruction;
  logic [ADDR_W-1:0]  if_pc;
  logic               fault;
  logic [ADDR_W-1:0]  fault_pc;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    output imem_address,
    input  imem_data,
    input  branch_valid,
    input  branch_target,
    output if_valid,
    input  if_ready,
    output if_instruction,
    output if_pc,
    output fault,
    output fault_pc,
    output fetch_count
  );

  modport slave (
    input  imem_address,
    output imem_data,
    output branch_valid,
    output branch_target,
    input  if_valid,
    output if_ready,
    input  if_instruction,
    input  if_pc,
    input  fault,
    input  fault_pc,
    input  fetch_count
  );

endinterface

// File: rtl/instruction_fetch_unit_reg_slice.sv
// Valid/ready fetch register holding {pc, instruction}.
// Flush beats load beats accept.
module fetch_reg_slice
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        accept,
  input  fetch_word_t din,
  output logic        valid,
  output fetch_word_t dout
);

  logic        valid_q, valid_d;
  fetch_word_t word_q, word_d;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      word_d  = din;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign valid = valid_q;
  assign dout  = word_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: pc sequencing, redirect/flush, fault capture
// and the valid/ready fetch register feeding decode.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                MEM_SIZE = 256,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  instruction_fetch_unit_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_PC =
    ADDR_W'(MEM_SIZE - INSTR_BYTES);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        br;
  logic        tgt_ok;
  logic        pc_ok;
  logic        valid;
  logic        accept;
  logic        load_en;
  logic        do_load;
  logic        do_fault;
  fetch_word_t din;
  fetch_word_t dout;

  assign br     = bus.branch_valid;
  assign tgt_ok = pc_legal(bus.branch_target, LAST_PC);
  assign pc_ok  = pc_legal(pc_q, LAST_PC);
  assign accept = valid && bus.if_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:  state_d = RUN;
      RUN:   if (do_fault) state_d = FAULT;
      FAULT: if (br && tgt_ok) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    load_en  = (state_q == RUN) &&
               (!valid || bus.if_ready) && !br;
    do_load  = load_en && pc_ok;
    do_fault = load_en && !pc_ok;
  end

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    cnt_d   = cnt_q;
    if (br) pc_d = bus.branch_target;
    else if (do_load) pc_d = pc_q + ADDR_W'(INSTR_BYTES);
    if (do_fault) begin
      fault_d = 1'b1;
      fpc_d   = pc_q;
    end else if (br && tgt_ok && state_q == FAULT) begin
      fault_d = 1'b0;
    end
    // a redirect kills the held word, so its handshake is not retired
    if (accept && !br) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      fpc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign din.pc    = pc_q;
  assign din.instr = bus.imem_data;

  fetch_reg_slice u_slice (
    .clk    (clk),
    .rst_n  (reset_n),
    .load   (do_load),
    .flush  (br),
    .accept (accept),
    .din    (din),
    .valid  (valid),
    .dout   (dout)
  );

  assign bus.imem_address   = pc_q;
  assign bus.if_valid       = valid;
  assign bus.if_instruction = dout.instr;
  assign bus.if_pc          = dout.pc;
  assign bus.fault          = fault_q;
  assign bus.fault_pc       = fpc_q;
  assign bus.fetch_count    = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios plus random
// ready/redirect traffic against a behavioural fetch model.
module tb_instruction_fetch_unit;

  localparam int MSZ = 16;
  localparam int MB = 0, MR = 1, MF = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] mem [4];

  instruction_fetch_unit_if #(.CNT_W(32)) bus();

  instruction_fetch_unit #(
    .MEM_SIZE (MSZ),
    .RESET_PC (64'h0),
    .CNT_W    (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memrd(input logic [63:0] a);
    if (a < 64'(MSZ)) return mem[a[3:2]];
    return 32'hdeadbeef;
  endfunction

  assign bus.imem_data = memrd(bus.imem_address);

  // reference model state
  int          m_st;
  logic [63:0] m_pc, m_ipc, m_fpc;
  logic [31:0] m_instr, m_cnt;
  bit          m_valid, m_fault;

  function automatic bit legal(input logic [63:0] a);
    return a[1:0] == 2'b00 && a <= 64'(MSZ - 4);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = MB; m_pc = 0; m_ipc = 0; m_fpc = 0;
    m_instr = 0; m_cnt = 0; m_valid = 0; m_fault = 0;
  endtask

  task automatic model_step(input bit rdy, input bit br,
                            input logic [63:0] tgt);
    bit acc, want, nv;
    int st0;
    st0  = m_st;
    acc  = m_valid && rdy;
    want = st0 == MR && (!m_valid || rdy) && !br;
    nv   = acc ? 1'b0 : m_valid;
    if (acc && !br) m_cnt = m_cnt + 1;
    if (st0 == MB) m_st = MR;
    if (br) begin
      nv = 0;
      if (st0 == MF && legal(tgt)) begin
        m_st = MR;
        m_fault = 0;
      end
      m_pc = tgt;
    end else if (want) begin
      if (legal(m_pc)) begin
        nv = 1;
        m_ipc = m_pc;
        m_instr = memrd(m_pc);
        m_pc = m_pc + 4;
      end else begin
        m_fault = 1;
        m_fpc = m_pc;
        m_st = MF;
      end
    end
    m_valid = nv;
  endtask

  task automatic check_all();
    chk("valid", 64'(bus.if_valid), 64'(m_valid));
    chk("if_pc", bus.if_pc, m_ipc);
    chk("instr", 64'(bus.if_instruction), 64'(m_instr));
    chk("addr", bus.imem_address, m_pc);
    chk("fault", 64'(bus.fault), 64'(m_fault));
    chk("fault_pc", bus.fault_pc, m_fpc);
    chk("count", 64'(bus.fetch_count), 64'(m_cnt));
  endtask

  // drive at negedge, step model, check at next negedge
  task automatic cyc(input bit rdy, input bit br,
                     input logic [63:0] tgt);
    bus.if_ready = rdy;
    bus.branch_valid = br;
    bus.branch_target = tgt;
    model_step(rdy, br, tgt);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [63:0] tl [8];
    mem[0] = 32'h8b1f03e5;
    mem[1] = 32'hf84000a4;
    mem[2] = 32'h8b040086;
    mem[3] = 32'hf80010a6;
    bus.if_ready = 0;
    bus.branch_valid = 0;
    bus.branch_target = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus.if_valid), 64'd0);
    chk("rst_count", 64'(bus.fetch_count), 64'd0);
    check_all();
    reset_n = 1;

    // sequential stream
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("seq0_pc", bus.if_pc, 64'h0);
    chk("seq0_in", 64'(bus.if_instruction), 64'h8b1f03e5);
    cyc(1, 0, 0);
    chk("seq1_pc", bus.if_pc, 64'h4);
    // stall
    repeat (3) begin
      cyc(0, 0, 0);
      chk("stall_in", 64'(bus.if_instruction), 64'hf84000a4);
      chk("stall_ad", bus.imem_address, 64'h8);
    end
    cyc(1, 0, 0);
    chk("rel_pc", bus.if_pc, 64'h8);
    // redirect discards held word
    cyc(1, 1, 64'h0);
    chk("br_valid", 64'(bus.if_valid), 64'd0);
    chk("br_count", 64'(bus.fetch_count), 64'd2);
    cyc(1, 0, 0);
    chk("br_pc", bus.if_pc, 64'h0);
    chk("br_in", 64'(bus.if_instruction), 64'h8b1f03e5);
    // run off the end
    repeat (3) cyc(1, 0, 0);
    chk("end_pc", bus.if_pc, 64'hc);
    cyc(1, 0, 0);
    chk("end_flt", 64'(bus.fault), 64'd1);
    chk("end_fpc", bus.fault_pc, 64'h10);
    chk("end_val", 64'(bus.if_valid), 64'd0);
    cyc(1, 1, 64'h4);
    chk("rec_flt", 64'(bus.fault), 64'd0);
    cyc(1, 0, 0);
    chk("rec_pc", bus.if_pc, 64'h4);
    // misaligned target
    cyc(1, 1, 64'h6);
    cyc(1, 0, 0);
    chk("mis_flt", 64'(bus.fault), 64'd1);
    chk("mis_fpc", bus.fault_pc, 64'h6);
    chk("mis_val", 64'(bus.if_valid), 64'd0);
    cyc(1, 1, 64'h8);
    cyc(1, 0, 0);
    chk("mis_rec", bus.if_pc, 64'h8);
    // async reset while stalled
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    #2 reset_n = 0;
    #1;
    model_reset();
    chk("arst_val", 64'(bus.if_valid), 64'd0);
    chk("arst_flt", 64'(bus.fault), 64'd0);
    chk("arst_cnt", 64'(bus.fetch_count), 64'd0);
    @(negedge clk);
    check_all();
    reset_n = 1;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rst2_pc", bus.if_pc, 64'h0);
    chk("rst2_in", 64'(bus.if_instruction), 64'h8b1f03e5);

    // random traffic
    tl[0] = 64'h0;  tl[1] = 64'h4;  tl[2] = 64'h8;
    tl[3] = 64'hc;  tl[4] = 64'h6;  tl[5] = 64'h10;
    tl[6] = 64'h2;  tl[7] = {$urandom, $urandom};
    for (int i = 0; i < 500; i++) begin
      bit r, b;
      logic [63:0] t;
      r = $urandom_range(0, 9) < 7;
      b = $urandom_range(0, 9) == 0;
      t = tl[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) t = {$urandom, $urandom};
      cyc(r, b, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
